// File: rtl/be_mem_ctrl.sv
// be_mem_ctrl: word-addressed RAM behind the cache back-end port.
// It serves single-word read and write requests with a fixed latency for each type.
// It also keeps saturating counters of accepted reads and writes.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | ready; a request with latency 1 completes on its accept edge
// WAIT   | request latched; down-counter runs until terminal count 1
module be_mem_ctrl #(
    parameter int    ADDR_W     = 32,
    parameter int    DATA_W     = 32,
    parameter int    MEM_ADDR_W = 12,
    parameter int    RD_LAT     = 2,
    parameter int    WR_LAT     = 1,
    parameter string INIT_FILE  = ""
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              be_valid_i,
    input  logic [ADDR_W-1:0] be_addr_i,
    input  logic [DATA_W-1:0] be_wdata_i,
    input  logic [3:0]        be_wstrb_i,
    output logic              be_ready_o,
    output logic [DATA_W-1:0] be_rdata_o,
    output logic              be_rvalid_o,
    output logic              err_o,
    output logic [15:0]       rd_cnt_o,
    output logic [15:0]       wr_cnt_o
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_WAIT   = 1'b1;
    localparam logic [3:0] RD_LAT_C = 4'(RD_LAT);
    localparam logic [3:0] WR_LAT_C = 4'(WR_LAT);

    logic [DATA_W-1:0] mem [0:(1<<MEM_ADDR_W)-1];

    logic [0:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [MEM_ADDR_W-1:0] idx_q, idx_d;
    logic                  oor_q, oor_d;
    logic                  wr_q, wr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  err_q, err_d;
    logic [15:0]           rd_cnt_q, rd_cnt_d;
    logic [15:0]           wr_cnt_q, wr_cnt_d;

    logic                  accept;
    logic                  req_wr;
    logic                  req_oor;
    logic [MEM_ADDR_W-1:0] req_idx;
    logic [3:0]            req_lat;
    logic                  done;
    logic                  op_wr;
    logic                  op_oor;
    logic [MEM_ADDR_W-1:0] op_idx;
    logic [DATA_W-1:0]     op_wdata;
    logic [3:0]            op_wstrb;
    logic                  unused_addr_lsbs;

    // The byte offset within a word carries no information for a word-wide RAM.
    assign unused_addr_lsbs = ^be_addr_i[1:0];

    assign be_ready_o = (state_q == S_IDLE);
    assign accept     = be_valid_i && be_ready_o;
    assign req_wr     = |be_wstrb_i;
    assign req_oor    = |be_addr_i[ADDR_W-1:MEM_ADDR_W+2];
    assign req_idx    = be_addr_i[MEM_ADDR_W+1:2];
    assign req_lat    = req_wr ? WR_LAT_C : RD_LAT_C;

    // Next-state, latency timer and completion; a latency-1 request completes from the live inputs.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        oor_d    = oor_q;
        wr_d     = wr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        done     = 1'b0;
        op_wr    = wr_q;
        op_oor   = oor_q;
        op_idx   = idx_q;
        op_wdata = wdata_q;
        op_wstrb = wstrb_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    idx_d   = req_idx;
                    oor_d   = req_oor;
                    wr_d    = req_wr;
                    wdata_d = be_wdata_i;
                    wstrb_d = be_wstrb_i;
                    cnt_d   = req_lat - 4'd1;
                    if (req_lat == 4'd1) begin
                        done     = 1'b1;
                        op_wr    = req_wr;
                        op_oor   = req_oor;
                        op_idx   = req_idx;
                        op_wdata = be_wdata_i;
                        op_wstrb = be_wstrb_i;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            default: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // Read response, sticky range error and saturating access counters.
    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        err_d    = err_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        if (done && !op_wr) begin
            rvalid_d = 1'b1;
            rdata_d  = op_oor ? '0 : mem[op_idx];
        end
        if (accept) begin
            if (req_oor) begin
                err_d = 1'b1;
            end
            if (req_wr) begin
                if (wr_cnt_q != 16'hFFFF) begin
                    wr_cnt_d = wr_cnt_q + 16'd1;
                end
            end else if (rd_cnt_q != 16'hFFFF) begin
                rd_cnt_d = rd_cnt_q + 16'd1;
            end
        end
    end

    // Control and status registers; RAM contents are deliberately outside the reset domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            oor_q    <= 1'b0;
            wr_q     <= 1'b0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            oor_q    <= oor_d;
            wr_q     <= wr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    // Byte-masked RAM write on the completing edge; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (reset_n && done && op_wr && !op_oor) begin
            for (int i = 0; i < 4; i++) begin
                if (op_wstrb[i]) begin
                    mem[op_idx][8*i +: 8] <= op_wdata[8*i +: 8];
                end
            end
        end
    end

    assign be_rdata_o  = rdata_q;
    assign be_rvalid_o = rvalid_q;
    assign err_o       = err_q;
    assign rd_cnt_o    = rd_cnt_q;
    assign wr_cnt_o    = wr_cnt_q;

endmodule

// File: tb/tb_be_mem_ctrl.sv
// Directed bench for be_mem_ctrl.
// Instance a uses RD_LAT=2 and WR_LAT=1; instance b uses latency 1 for both.
// Inputs are driven, and outputs sampled, 1 ns after each rising edge.
module tb_be_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;

    logic        a_valid = 1'b0;
    logic [31:0] a_addr = '0;
    logic [31:0] a_wdata = '0;
    logic [3:0]  a_wstrb = '0;
    logic        a_ready, a_rvalid, a_err;
    logic [31:0] a_rdata;
    logic [15:0] a_rd_cnt, a_wr_cnt;

    logic        b_valid = 1'b0;
    logic [31:0] b_addr = '0;
    logic [31:0] b_wdata = '0;
    logic [3:0]  b_wstrb = '0;
    logic        b_ready, b_rvalid, b_err;
    logic [31:0] b_rdata;
    logic [15:0] b_rd_cnt, b_wr_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    be_mem_ctrl #(.RD_LAT(2), .WR_LAT(1)) u_dut_a (
        .clk(clk), .reset_n(reset_n),
        .be_valid_i(a_valid), .be_addr_i(a_addr), .be_wdata_i(a_wdata), .be_wstrb_i(a_wstrb),
        .be_ready_o(a_ready), .be_rdata_o(a_rdata), .be_rvalid_o(a_rvalid),
        .err_o(a_err), .rd_cnt_o(a_rd_cnt), .wr_cnt_o(a_wr_cnt)
    );

    be_mem_ctrl #(.RD_LAT(1), .WR_LAT(1)) u_dut_b (
        .clk(clk), .reset_n(reset_n),
        .be_valid_i(b_valid), .be_addr_i(b_addr), .be_wdata_i(b_wdata), .be_wstrb_i(b_wstrb),
        .be_ready_o(b_ready), .be_rdata_o(b_rdata), .be_rvalid_o(b_rvalid),
        .err_o(b_err), .rd_cnt_o(b_rd_cnt), .wr_cnt_o(b_wr_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_req(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        a_valid = 1'b1;
        a_addr  = addr;
        a_wdata = data;
        a_wstrb = strb;
    endtask

    // Single read on instance a: rvalid must rise exactly two cycles after acceptance.
    task automatic a_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        chk({tag, "_ready"}, 32'(a_ready), 32'd1);
        a_req(addr, 32'h0, 4'h0);
        tick();
        a_valid = 1'b0;
        chk({tag, "_rv_t1"}, 32'(a_rvalid), 32'd0);
        chk({tag, "_busy_t1"}, 32'(a_ready), 32'd0);
        tick();
        chk({tag, "_rv_t2"}, 32'(a_rvalid), 32'd1);
        chk({tag, "_data"}, a_rdata, exp);
        tick();
        chk({tag, "_rv_t3"}, 32'(a_rvalid), 32'd0);
        chk({tag, "_hold"}, a_rdata, exp);
    endtask

    task automatic a_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        a_req(addr, data, strb);
        tick();
        a_valid = 1'b0;
        a_wstrb = 4'h0;
    endtask

    initial begin
        // Asynchronous reset asserted mid-cycle must take effect without a clock edge.
        tick();
        tick();
        #3;
        reset_n = 1'b0;
        #1;
        chk("rst_ready", 32'(a_ready), 32'd1);
        chk("rst_rvalid", 32'(a_rvalid), 32'd0);
        chk("rst_rdata", a_rdata, 32'h0);
        chk("rst_err", 32'(a_err), 32'd0);
        chk("rst_rdcnt", 32'(a_rd_cnt), 32'd0);
        chk("rst_wrcnt", 32'(a_wr_cnt), 32'd0);
        chk("rst_b_ready", 32'(b_ready), 32'd1);
        tick();
        tick();
        #3;
        reset_n = 1'b1;
        tick();

        // Full write then read-back with the two-cycle read latency.
        a_write(32'h0000_0010, 32'hDEADBEEF, 4'hF);
        chk("wr_ready_after", 32'(a_ready), 32'd1);
        chk("wr_cnt1", 32'(a_wr_cnt), 32'd1);
        a_read("rd1", 32'h0000_0010, 32'hDEADBEEF);
        chk("rd_cnt1", 32'(a_rd_cnt), 32'd1);

        // Only byte lane 2 is updated by a partial write.
        a_write(32'h0000_0010, 32'h00AA_0000, 4'b0100);
        a_read("rd_part", 32'h0000_0010, 32'hDEAABEEF);

        // Out-of-range accesses: read returns zero, error is sticky, write is dropped.
        a_write(32'h0000_0000, 32'hCAFEF00D, 4'hF);
        chk("err_before", 32'(a_err), 32'd0);
        a_req(32'h0001_0000, 32'h0, 4'h0);
        tick();
        a_valid = 1'b0;
        chk("err_t1", 32'(a_err), 32'd1);
        tick();
        chk("oor_rvalid", 32'(a_rvalid), 32'd1);
        chk("oor_rdata", a_rdata, 32'h0);
        tick();
        a_write(32'h0001_0000, 32'h1234_5678, 4'hF);
        chk("err_sticky", 32'(a_err), 32'd1);
        a_read("rd_word0", 32'h0000_0000, 32'hCAFEF00D);
        chk("err_sticky2", 32'(a_err), 32'd1);

        // Reset pulse while waiting on a read: the response is dropped, RAM survives.
        a_req(32'h0000_0010, 32'h0, 4'h0);
        tick();
        a_valid = 1'b0;
        chk("wait_busy", 32'(a_ready), 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_ready", 32'(a_ready), 32'd1);
        chk("midrst_err", 32'(a_err), 32'd0);
        chk("midrst_rdcnt", 32'(a_rd_cnt), 32'd0);
        #2;
        reset_n = 1'b1;
        tick();
        chk("midrst_norv1", 32'(a_rvalid), 32'd0);
        tick();
        chk("midrst_norv2", 32'(a_rvalid), 32'd0);
        chk("midrst_ready2", 32'(a_ready), 32'd1);
        a_read("rd_after_rst", 32'h0000_0010, 32'hDEAABEEF);

        // Instance b: back-to-back writes filling 0x40..0x5C.
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("b_wr_ready%0d", i), 32'(b_ready), 32'd1);
            b_valid = 1'b1;
            b_addr  = 32'h40 + 32'(4 * i);
            b_wdata = 32'h1000_0000 + 32'(i);
            b_wstrb = 4'hF;
            tick();
        end
        chk("b_wr_cnt", 32'(b_wr_cnt), 32'd8);

        // Back-to-back reads: one response per cycle, in order.
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("b_rd_ready%0d", i), 32'(b_ready), 32'd1);
            b_valid = 1'b1;
            b_addr  = 32'h40 + 32'(4 * i);
            b_wstrb = 4'h0;
            tick();
            chk($sformatf("b_rv%0d", i), 32'(b_rvalid), 32'd1);
            chk($sformatf("b_rd%0d", i), b_rdata, 32'h1000_0000 + 32'(i));
        end
        chk("b_rd_cnt8", 32'(b_rd_cnt), 32'd8);
        b_valid = 1'b0;
        tick();
        chk("b_rv_off", 32'(b_rvalid), 32'd0);

        // Read counter saturation: 65535 total reads, then further reads must not wrap.
        b_valid = 1'b1;
        b_addr  = 32'h40;
        for (int i = 0; i < 65535 - 8 - 1; i++) begin
            tick();
        end
        chk("b_cnt_fffe", 32'(b_rd_cnt), 32'h0000_FFFE);
        tick();
        chk("b_cnt_ffff", 32'(b_rd_cnt), 32'h0000_FFFF);
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        chk("b_cnt_sat", 32'(b_rd_cnt), 32'h0000_FFFF);
        chk("b_wr_cnt_hold", 32'(b_wr_cnt), 32'd8);
        b_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
